cmd_exec: RTL and testbench
===========================

CMD_EXEC -- requirements
Module: cmd_exec

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, width of the memory-write address counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  command word present.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid&cmd_ready at a rising edge.
REQ-006 SHALL have port cmd_data  input  64  packed command: [63:48] opcode, [47:32] dest, [31:16] opA, [15:0] opB.
REQ-007 SHALL have port res_valid  output  1  register-destined result present.
REQ-008 SHALL have port res_ready  input  1  result consumed when res_valid&res_ready.
REQ-009 SHALL have port res_data  output  16  ALU result.
REQ-010 SHALL have port res_carry  output  1  ADD carry-out / SUB borrow.
REQ-011 SHALL have port bus_wr_req  output  1  memory write request, held until acknowledged.
REQ-012 SHALL have port bus_wr_ack  input  1  write completes on bus_wr_req&bus_wr_ack.
REQ-013 SHALL have port bus_addr  output  ADDR_W  write address.
REQ-014 SHALL have port bus_wdata  output  16  write data.
REQ-015 SHALL have port err_pulse  output  1  one-cycle pulse on dropped illegal command.
REQ-016 SHALL have port err_cnt  output  8  count of illegal commands.

Function
REQ-017 SHALL decode opcode 16'h0000=ADD, 16'h0001=SUB; dest 16'h0000=REG, 16'h0001=MEM; any other value is illegal.
REQ-018 SHALL implement FSM states IDLE, EXEC, REG_OUT, MEM_WR; cmd_ready=1 only in IDLE.
REQ-019 SHALL on acceptance in IDLE capture cmd_data into an internal register and enter EXEC next cycle.
REQ-020 SHALL in EXEC compute ADD as {res_carry,res_data}=opA+opB (17-bit); SUB as res_data=(opA-opB) mod 2^16, res_carry=(opA<opB).
REQ-021 SHALL in EXEC, for illegal opcode or dest, pulse err_pulse for exactly that cycle, increment err_cnt saturating at 8'hFF, and return to IDLE with no result or bus write.
REQ-022 SHALL from EXEC go to REG_OUT (dest REG) or MEM_WR (dest MEM); res_valid/bus_wr_req assert 2 cycles after acceptance.
REQ-023 SHALL in REG_OUT hold res_valid, res_data, res_carry stable until res_ready, then return to IDLE.
REQ-024 SHALL in MEM_WR hold bus_wr_req, bus_addr, bus_wdata stable until bus_wr_ack, then increment the address counter (wrap 2^ADDR_W-1 -> 0) and return to IDLE.
REQ-025 SHALL ignore bus_wr_ack outside MEM_WR and res_ready outside REG_OUT.
REQ-026 SHALL permit back-to-back throughput of one command per 3 cycles when res_ready/bus_wr_ack are tied high.

Reset
REQ-027 SHALL on reset force state IDLE, address counter 0, err_cnt 0, and all outputs 0 except cmd_ready which becomes 1 the cycle after reset deasserts.
REQ-028 SHALL on reset mid-operation abandon the command; bus_wr_req and res_valid deassert the cycle after reset sampled high; no counter increment.

Structure
REQ-029 SHALL take opcode/dest enums, the 64-bit command struct and the FSM state enum from shared package design_types.
REQ-030 SHALL place the 17-bit add/subtract datapath in one sub-module cmd_alu; FSM, counters and handshakes stay in cmd_exec.

Verification
REQ-031 SHALL cover: ADD/REG, opA=16'h0001, opB=16'h0002 -> res_valid 2 cycles after accept, res_data=16'h0003, res_carry=0.
REQ-032 SHALL cover: SUB/REG, opA=16'h0005, opB=16'h0006, res_ready low 4 cycles -> res_data=16'hFFFF, res_carry=1, held stable all 4 cycles.
REQ-033 SHALL cover: 257 ADD/MEM commands (ADDR_W=8) with bus_wr_ack delayed 0-3 cycles -> bus_addr 0..255 then 0, bus_wdata matches each sum.
REQ-034 SHALL cover: opcode 16'h0002 then dest 16'h0007 -> two err_pulse cycles, err_cnt=2, no res_valid/bus_wr_req; 300 illegal commands -> err_cnt=8'hFF.
REQ-035 SHALL cover: reset asserted during MEM_WR with ack withheld -> bus_wr_req low next cycle, next MEM write uses bus_addr 0.
REQ-036 SHALL cover: ADD 16'hFFFF+16'h0001 -> res_data=16'h0000, res_carry=1; cmd_ready low in EXEC/REG_OUT/MEM_WR.

Source files
------------

// File: rtl/design_types.sv
// Shared types for the command executor: command word layout, opcode/dest
// encodings and the controller state encoding.
package design_types;

  typedef enum logic [15:0] {
    OP_ADD = 16'h0000,
    OP_SUB = 16'h0001
  } opcode_e;

  typedef enum logic [15:0] {
    DEST_REG = 16'h0000,
    DEST_MEM = 16'h0001
  } dest_e;

  typedef struct packed {
    logic [15:0] opcode;
    logic [15:0] dest;
    logic [15:0] op_a;
    logic [15:0] op_b;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    REG_OUT = 2'd2,
    MEM_WR  = 2'd3
  } state_e;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  function automatic logic cmd_is_legal(input cmd_t c);
    logic w_op_ok;
    logic w_dest_ok;
    w_op_ok   = (c.opcode == OP_ADD) || (c.opcode == OP_SUB);
    w_dest_ok = (c.dest == DEST_REG) || (c.dest == DEST_MEM);
    return w_op_ok && w_dest_ok;
  endfunction

endpackage

// File: rtl/cmd_alu.sv
// 17-bit add/subtract datapath; bit 16 is ADD carry-out or SUB borrow.
module cmd_alu
  import design_types::*;
(
  input  logic [15:0] i_op_a,
  input  logic [15:0] i_op_b,
  input  logic [15:0] i_opcode,
  output logic [15:0] o_result,
  output logic        o_carry
);

  logic [16:0] w_sum;

  // Zero-extended subtract leaves the borrow (opA < opB) in bit 16.
  always_comb begin
    w_sum = 17'd0;
    if (i_opcode == OP_SUB) begin
      w_sum = {1'b0, i_op_a} - {1'b0, i_op_b};
    end else begin
      w_sum = {1'b0, i_op_a} + {1'b0, i_op_b};
    end
  end

  assign o_result = w_sum[15:0];
  assign o_carry  = w_sum[16];

endmodule

// File: rtl/cmd_exec.sv
// Command executor: accepts packed ADD/SUB commands, returns results on a
// register port or writes them to sequential memory addresses.
module cmd_exec
  import design_types::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [63:0]       cmd_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [15:0]       res_data,
  output logic              res_carry,
  output logic              bus_wr_req,
  input  logic              bus_wr_ack,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [15:0]       bus_wdata,
  output logic              err_pulse,
  output logic [7:0]        err_cnt
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            r_state;
  state_e            w_next_state;
  cmd_t              r_cmd;
  cmd_t              w_cmd_in;
  logic              w_accept;
  logic              w_legal;
  logic              w_in_legal;
  logic [15:0]       w_alu_res;
  logic              w_alu_carry;

  logic              r_cmd_ready;
  logic              r_res_valid;
  logic [15:0]       r_res_data;
  logic              r_res_carry;
  logic              r_bus_wr_req;
  logic [15:0]       r_bus_wdata;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err_pulse;
  logic [7:0]        r_err_cnt;

  assign w_cmd_in   = cmd_data;
  assign w_accept   = cmd_valid & r_cmd_ready;
  assign w_legal    = cmd_is_legal(r_cmd);
  assign w_in_legal = cmd_is_legal(w_cmd_in);

  cmd_alu u_alu (
    .i_op_a   (r_cmd.op_a),
    .i_op_b   (r_cmd.op_b),
    .i_opcode (r_cmd.opcode),
    .o_result (w_alu_res),
    .o_carry  (w_alu_carry)
  );

  // Controller state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next_state = EXEC;
        else          w_next_state = IDLE;
      end
      EXEC: begin
        if (!w_legal)                   w_next_state = IDLE;
        else if (r_cmd.dest == DEST_MEM) w_next_state = MEM_WR;
        else                            w_next_state = REG_OUT;
      end
      REG_OUT: begin
        if (res_ready) w_next_state = IDLE;
        else           w_next_state = REG_OUT;
      end
      MEM_WR: begin
        if (bus_wr_ack) w_next_state = IDLE;
        else            w_next_state = MEM_WR;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Command capture on acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd <= '0;
    end else if (w_accept) begin
      r_cmd <= w_cmd_in;
    end else begin
      r_cmd <= r_cmd;
    end
  end

  // Ready follows the next state so it is high exactly while in IDLE;
  // the error pulse is decoded at acceptance so it lines up with EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd_ready <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= 8'd0;
    end else begin
      r_cmd_ready <= (w_next_state == IDLE);
      r_err_pulse <= w_accept & ~w_in_legal;
      if ((r_state == EXEC) && !w_legal && (r_err_cnt != ERR_CNT_MAX)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end else begin
        r_err_cnt <= r_err_cnt;
      end
    end
  end

  // Register-destined result port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_res_valid <= 1'b0;
      r_res_data  <= 16'd0;
      r_res_carry <= 1'b0;
    end else if ((r_state == EXEC) && (w_next_state == REG_OUT)) begin
      r_res_valid <= 1'b1;
      r_res_data  <= w_alu_res;
      r_res_carry <= w_alu_carry;
    end else if ((r_state == REG_OUT) && res_ready) begin
      r_res_valid <= 1'b0;
      r_res_data  <= r_res_data;
      r_res_carry <= r_res_carry;
    end else begin
      r_res_valid <= r_res_valid;
      r_res_data  <= r_res_data;
      r_res_carry <= r_res_carry;
    end
  end

  // Memory write port and wrapping address counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bus_wr_req <= 1'b0;
      r_bus_wdata  <= 16'd0;
      r_addr       <= '0;
    end else if ((r_state == EXEC) && (w_next_state == MEM_WR)) begin
      r_bus_wr_req <= 1'b1;
      r_bus_wdata  <= w_alu_res;
      r_addr       <= r_addr;
    end else if ((r_state == MEM_WR) && bus_wr_ack) begin
      r_bus_wr_req <= 1'b0;
      r_bus_wdata  <= r_bus_wdata;
      r_addr       <= r_addr + ADDR_ONE;
    end else begin
      r_bus_wr_req <= r_bus_wr_req;
      r_bus_wdata  <= r_bus_wdata;
      r_addr       <= r_addr;
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_carry  = r_res_carry;
  assign bus_wr_req = r_bus_wr_req;
  assign bus_addr   = r_addr;
  assign bus_wdata  = r_bus_wdata;
  assign err_pulse  = r_err_pulse;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_cmd_exec.sv
// Self-checking bench for cmd_exec: directed corner cases plus randomized
// commands checked against an arithmetic reference model.
module tb_cmd_exec;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [63:0] cmd_data = 64'd0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        res_carry;
  logic        bus_wr_req;
  logic        bus_wr_ack = 1'b0;
  logic [7:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic        err_pulse;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  int exp_addr = 0;
  int exp_err = 0;

  typedef struct {
    bit          is_mem;
    logic [16:0] r;
  } exp_t;
  exp_t exp_q[$];

  cmd_exec #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry), .bus_wr_req(bus_wr_req),
    .bus_wr_ack(bus_wr_ack), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: {carry, result} from plain integer arithmetic.
  function automatic logic [16:0] model(input logic [15:0] op, input logic [15:0] a, input logic [15:0] b);
    int unsigned av = a;
    int unsigned bv = b;
    int unsigned r;
    if (op == 16'd1) begin
      r = (av - bv) & 32'h0000_FFFF;
      if (av < bv) r = r | 32'h0001_0000;
    end else begin
      r = av + bv;
    end
    return r[16:0];
  endfunction

  task automatic send_cmd(input logic [15:0] op, input logic [15:0] dest,
                          input logic [15:0] a, input logic [15:0] b);
    int budget = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = {op, dest, a, b};
    while (cmd_ready !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, res_valid, res_carry, bus_wr_req, err_pulse} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 00000",
               {cmd_ready, res_valid, res_carry, bus_wr_req, err_pulse});
    end
    checks++;
    if ({res_data, bus_wdata, bus_addr, err_cnt} !== 48'd0) begin
      errors++;
      $display("FAIL reset_values: got %h required 0", {res_data, bus_wdata, bus_addr, err_cnt});
    end
    reset = 1'b0;
    exp_addr = 0;
    exp_err = 0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_add_reg();
    logic [15:0] av [2] = '{16'h0001, 16'hFFFF};
    logic [15:0] bv [2] = '{16'h0002, 16'h0001};
    logic [15:0] ed [2] = '{16'h0003, 16'h0000};
    logic        ec [2] = '{1'b0, 1'b1};
    for (int k = 0; k < 2; k++) begin
      res_ready = 1'b0;
      send_cmd(16'h0000, 16'h0000, av[k], bv[k]);
      checks++;
      if ({res_valid, cmd_ready, bus_wr_req} !== 3'b000) begin
        errors++;
        $display("FAIL add_exec_flags: got %b required 000", {res_valid, cmd_ready, bus_wr_req});
      end
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== ed[k] || res_carry !== ec[k] || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL add_result: valid=%b data=%h carry=%b ready=%b required 1 %h %b 0",
                 res_valid, res_data, res_carry, cmd_ready, ed[k], ec[k]);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL add_release: valid=%b ready=%b required 0 1", res_valid, cmd_ready);
      end
    end
  endtask

  task automatic test_sub_hold();
    res_ready = 1'b0;
    send_cmd(16'h0001, 16'h0000, 16'h0005, 16'h0006);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res_valid !== 1'b1 || res_data !== 16'hFFFF || res_carry !== 1'b1) begin
        errors++;
        $display("FAIL sub_hold[%0d]: valid=%b data=%h carry=%b required 1 ffff 1",
                 i, res_valid, res_data, res_carry);
      end
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL sub_release: valid=%b required 0", res_valid);
    end
  endtask

  task automatic test_random_reg();
    for (int n = 0; n < 24; n++) begin
      logic [15:0] op = 16'($urandom_range(0, 1));
      logic [15:0] a = 16'($urandom);
      logic [15:0] b = 16'($urandom);
      logic [16:0] e = model(op, a, b);
      int dly = $urandom_range(0, 3);
      send_cmd(op, 16'h0000, a, b);
      @(negedge clk);
      for (int d = 0; d <= dly; d++) begin
        checks++;
        if (res_valid !== 1'b1 || {res_carry, res_data} !== e || bus_wr_req !== 1'b0 ||
            bus_addr !== 8'(exp_addr)) begin
          errors++;
          $display("FAIL rand_reg[%0d]: valid=%b cr=%h req=%b addr=%h required 1 %h 0 %h",
                   n, res_valid, {res_carry, res_data}, bus_wr_req, bus_addr, e, 8'(exp_addr));
        end
        res_ready  = (d == dly);
        bus_wr_ack = 1'($urandom);
        @(negedge clk);
      end
      res_ready  = 1'b0;
      bus_wr_ack = 1'b0;
      checks++;
      if (res_valid !== 1'b0) begin
        errors++;
        $display("FAIL rand_reg_release[%0d]: valid=%b required 0", n, res_valid);
      end
    end
  endtask

  task automatic test_illegal();
    for (int n = 0; n < 300; n++) begin
      logic [15:0] op = 16'($urandom);
      logic [15:0] dest = 16'($urandom);
      if (n == 0) begin
        op = 16'h0002; dest = 16'h0000;
      end else if (n == 1) begin
        op = 16'h0000; dest = 16'h0007;
      end else if (op < 16'd2 && dest < 16'd2) begin
        op = 16'h0002;
      end
      send_cmd(op, dest, 16'($urandom), 16'($urandom));
      checks++;
      if (err_pulse !== 1'b1 || res_valid !== 1'b0 || bus_wr_req !== 1'b0) begin
        errors++;
        $display("FAIL illegal_pulse[%0d]: pulse=%b valid=%b req=%b required 1 0 0",
                 n, err_pulse, res_valid, bus_wr_req);
      end
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      @(negedge clk);
      checks++;
      if (err_pulse !== 1'b0 || err_cnt !== 8'(exp_err) || res_valid !== 1'b0 ||
          bus_wr_req !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL illegal_after[%0d]: pulse=%b cnt=%h valid=%b req=%b ready=%b required 0 %h 0 0 1",
                 n, err_pulse, err_cnt, res_valid, bus_wr_req, cmd_ready, 8'(exp_err));
      end
      if (n == 1) begin
        checks++;
        if (err_cnt !== 8'd2) begin
          errors++;
          $display("FAIL illegal_two: err_cnt=%h required 02", err_cnt);
        end
      end
    end
    checks++;
    if (err_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL illegal_saturate: err_cnt=%h required ff", err_cnt);
    end
  endtask

  task automatic test_mem_wrap();
    for (int n = 0; n < 257; n++) begin
      logic [15:0] a = 16'($urandom);
      logic [15:0] b = 16'($urandom);
      logic [16:0] e = model(16'h0000, a, b);
      int dly = $urandom_range(0, 3);
      send_cmd(16'h0000, 16'h0001, a, b);
      checks++;
      if (bus_wr_req !== 1'b0) begin
        errors++;
        $display("FAIL mem_early[%0d]: req=%b required 0", n, bus_wr_req);
      end
      @(negedge clk);
      for (int d = 0; d <= dly; d++) begin
        checks++;
        if (bus_wr_req !== 1'b1 || bus_addr !== 8'(exp_addr) || bus_wdata !== e[15:0] ||
            res_valid !== 1'b0 || cmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL mem_write[%0d]: req=%b addr=%h wdata=%h valid=%b ready=%b required 1 %h %h 0 0",
                   n, bus_wr_req, bus_addr, bus_wdata, res_valid, cmd_ready, 8'(exp_addr), e[15:0]);
        end
        bus_wr_ack = (d == dly);
        @(negedge clk);
      end
      bus_wr_ack = 1'b0;
      exp_addr = (exp_addr + 1) % 256;
      checks++;
      if (bus_wr_req !== 1'b0 || bus_addr !== 8'(exp_addr)) begin
        errors++;
        $display("FAIL mem_done[%0d]: req=%b addr=%h required 0 %h", n, bus_wr_req, bus_addr, 8'(exp_addr));
      end
    end
  endtask

  task automatic test_back_to_back();
    int   last_acc = -1;
    int   n_acc = 0;
    logic acc_prev = 1'b0;
    exp_t ent;
    res_ready  = 1'b1;
    bus_wr_ack = 1'b1;
    @(negedge clk);
    cmd_data  = {16'($urandom_range(0, 1)), 16'($urandom_range(0, 1)), 16'($urandom), 16'($urandom)};
    cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (res_valid === 1'b1 || bus_wr_req === 1'b1) begin
        checks++;
        if (exp_q.size() == 0 || cmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_unexpected: cyc=%0d qsize=%0d ready=%b required >0 0",
                   cyc, exp_q.size(), cmd_ready);
        end else begin
          ent = exp_q.pop_front();
          if (ent.is_mem) begin
            if (bus_wr_req !== 1'b1 || res_valid !== 1'b0 || bus_wdata !== ent.r[15:0] ||
                bus_addr !== 8'(exp_addr)) begin
              errors++;
              $display("FAIL b2b_mem: cyc=%0d req=%b valid=%b wdata=%h addr=%h required 1 0 %h %h",
                       cyc, bus_wr_req, res_valid, bus_wdata, bus_addr, ent.r[15:0], 8'(exp_addr));
            end
            exp_addr = (exp_addr + 1) % 256;
          end else if (res_valid !== 1'b1 || bus_wr_req !== 1'b0 || {res_carry, res_data} !== ent.r) begin
            errors++;
            $display("FAIL b2b_reg: cyc=%0d valid=%b req=%b cr=%h required 1 0 %h",
                     cyc, res_valid, bus_wr_req, {res_carry, res_data}, ent.r);
          end
        end
      end
      if (acc_prev) begin
        cmd_data  = {16'($urandom_range(0, 1)), 16'($urandom_range(0, 1)), 16'($urandom), 16'($urandom)};
        cmd_valid = (n_acc < 15);
      end
      acc_prev = cmd_valid && (cmd_ready === 1'b1);
      if (acc_prev) begin
        ent.is_mem = (cmd_data[47:32] == 16'h0001);
        ent.r = model(cmd_data[63:48], cmd_data[31:16], cmd_data[15:0]);
        exp_q.push_back(ent);
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != 3) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles required 3", cyc - last_acc);
          end
        end
        last_acc = cyc;
        n_acc++;
      end
      @(negedge clk);
    end
    cmd_valid  = 1'b0;
    res_ready  = 1'b0;
    bus_wr_ack = 1'b0;
    checks++;
    if (n_acc != 15 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: accepted=%0d pending=%0d required 15 0", n_acc, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [16:0] e = model(16'h0000, 16'h1234, 16'h1111);
    bus_wr_ack = 1'b0;
    send_cmd(16'h0000, 16'h0001, 16'h0102, 16'h0304);
    @(negedge clk);
    checks++;
    if (bus_wr_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: req=%b required 1", bus_wr_req);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_addr = 0;
    exp_err = 0;
    checks++;
    if (bus_wr_req !== 1'b0 || res_valid !== 1'b0 || bus_addr !== 8'd0 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid_post: req=%b valid=%b addr=%h cnt=%h required 0 0 00 00",
               bus_wr_req, res_valid, bus_addr, err_cnt);
    end
    send_cmd(16'h0000, 16'h0001, 16'h1234, 16'h1111);
    @(negedge clk);
    checks++;
    if (bus_wr_req !== 1'b1 || bus_addr !== 8'd0 || bus_wdata !== e[15:0]) begin
      errors++;
      $display("FAIL rst_mid_next: req=%b addr=%h wdata=%h required 1 00 %h",
               bus_wr_req, bus_addr, bus_wdata, e[15:0]);
    end
    bus_wr_ack = 1'b1;
    @(negedge clk);
    bus_wr_ack = 1'b0;
    checks++;
    if (bus_wr_req !== 1'b0 || bus_addr !== 8'd1) begin
      errors++;
      $display("FAIL rst_mid_ack: req=%b addr=%h required 0 01", bus_wr_req, bus_addr);
    end
  endtask

  initial begin
    test_reset();
    test_add_reg();
    test_sub_hold();
    test_random_reg();
    test_illegal();
    test_mem_wrap();
    test_back_to_back();
    test_reset_mid_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
